rr_x_in_arb: RTL and testbench

Registered round-robin arbiter for IO_SIZE requesters, built on a right-rotate-by-pointer priority scheme. It keeps a priority pointer that wraps modulo IO_SIZE, so any IO_SIZE works, not only powers of two. It can optionally lock a grant for a multi-cycle transfer such as a wormhole packet. It sits in front of each router output port (crossbar/switch allocation) and in any shared-resource selector in the NoC.

---
 rtl/rr_x_in_arb.sv | 91 +++++++++
 tb/tb_rr_x_in_arb.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/rr_x_in_arb.sv
// Round-robin arbiter over IO_SIZE requesters with a modulo-IO_SIZE priority pointer and optional grant lock.
// Grants are registered one cycle after req_in is sampled; there is no backpressure, and a grant lasts one cycle unless locked by hold_in.
module rr_x_in_arb #(
  parameter int IO_SIZE   = 5,
  parameter int IO_w      = 3,
  parameter int HOLD_MODE = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IO_SIZE-1:0] req_in,
  input  logic               hold_in,
  output logic [IO_SIZE-1:0] grant_out,
  output logic [IO_w-1:0]    grant_id_out,
  output logic               grant_valid_out
);

  localparam int            W1     = IO_w + 1;
  localparam logic [IO_w:0] SIZE_W = W1'(IO_SIZE);

  // Add two in-range indices and fold back into 0..IO_SIZE-1; never relies on a 2^IO_w wrap.
  function automatic logic [IO_w-1:0] wrap_add(input logic [IO_w-1:0] a,
                                               input logic [IO_w-1:0] b);
    logic [IO_w:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= SIZE_W) s = s - SIZE_W;
    return s[IO_w-1:0];
  endfunction

  logic [IO_w-1:0]    ptr;
  logic [IO_w-1:0]    ptr_nx;
  logic [IO_SIZE-1:0] rot;
  logic [IO_w-1:0]    k;
  logic [IO_w-1:0]    win;
  logic               any_req;
  logic               locked;
  logic [IO_SIZE-1:0] grant_nx;
  logic [IO_w-1:0]    grant_id_nx;
  logic               grant_valid_nx;

  always_comb begin
    rot = '0;
    for (int j = 0; j < IO_SIZE; j++) begin
      rot[j] = req_in[wrap_add(IO_w'(j), ptr)];
    end
  end

  // Scan from the top so the last assignment is the lowest set bit.
  always_comb begin
    k = '0;
    for (int j = IO_SIZE - 1; j >= 0; j--) begin
      if (rot[j]) k = IO_w'(j);
    end
  end

  assign any_req = |req_in;
  assign win     = wrap_add(k, ptr);
  assign locked  = (HOLD_MODE != 0) && grant_valid_out && hold_in && req_in[grant_id_out];

  always_comb begin
    ptr_nx         = ptr;
    grant_nx       = grant_out;
    grant_id_nx    = grant_id_out;
    grant_valid_nx = grant_valid_out;
    if (!locked) begin
      if (any_req) begin
        grant_nx       = IO_SIZE'(1) << win;
        grant_id_nx    = win;
        grant_valid_nx = 1'b1;
        ptr_nx         = wrap_add(win, IO_w'(1));
      end else begin
        grant_nx       = '0;
        grant_valid_nx = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr             <= '0;
      grant_out       <= '0;
      grant_id_out    <= '0;
      grant_valid_out <= 1'b0;
    end else begin
      ptr             <= ptr_nx;
      grant_out       <= grant_nx;
      grant_id_out    <= grant_id_nx;
      grant_valid_out <= grant_valid_nx;
    end
  end

endmodule

// File: tb/tb_rr_x_in_arb.sv
// Randomized and directed bench for rr_x_in_arb, free-running and grant-lock builds side by side.
module tb_rr_x_in_arb;

  typedef struct {
    logic [4:0] g;
    logic [2:0] id;
    logic       v;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] req = 5'b11111;
  logic       hold = 1'b0;

  logic [4:0] g_free, g_hold;
  logic [2:0] id_free, id_hold;
  logic       v_free, v_hold;

  int checks = 0;
  int failures = 0;

  exp_t q0[$];
  exp_t q1[$];

  int m_ptr[2];
  int m_id[2];
  bit m_v[2];

  always #5 clk = ~clk;

  rr_x_in_arb #(.IO_SIZE(5), .IO_w(3), .HOLD_MODE(0)) u_free (
    .clk(clk), .rst(rst), .req_in(req), .hold_in(hold),
    .grant_out(g_free), .grant_id_out(id_free), .grant_valid_out(v_free)
  );

  rr_x_in_arb #(.IO_SIZE(5), .IO_w(3), .HOLD_MODE(1)) u_hold (
    .clk(clk), .rst(rst), .req_in(req), .hold_in(hold),
    .grant_out(g_hold), .grant_id_out(id_hold), .grant_valid_out(v_hold)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic push(input int d);
    exp_t e;
    e.v  = m_v[d];
    e.id = 3'(m_id[d]);
    e.g  = m_v[d] ? (5'b00001 << m_id[d]) : 5'b00000;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic model_reset(input int d);
    m_ptr[d] = 0;
    m_id[d]  = 0;
    m_v[d]   = 1'b0;
  endtask

  // Reference behaviour: search from ptr upward modulo 5 for the first requester.
  task automatic model_step(input int d, input logic [4:0] r, input logic h);
    if (d == 1 && m_v[d] && h && r[m_id[d]]) begin
      // locked: nothing moves
    end else if (r == 5'b0) begin
      m_v[d] = 1'b0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        int c;
        c = (m_ptr[d] + i) % 5;
        if (r[c]) begin
          m_id[d]  = c;
          m_v[d]   = 1'b1;
          m_ptr[d] = (c + 1) % 5;
          break;
        end
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_free_grant"}, int'(g_free), 0);
    chk({tag, "_free_id"},    int'(id_free), 0);
    chk({tag, "_free_valid"}, int'(v_free), 0);
    chk({tag, "_hold_grant"}, int'(g_hold), 0);
    chk({tag, "_hold_id"},    int'(id_hold), 0);
    chk({tag, "_hold_valid"}, int'(v_hold), 0);
  endtask

  task automatic cyc(input logic [4:0] r, input logic h, input logic rs);
    @(negedge clk);
    req  = r;
    hold = h;
    rst  = rs;
    for (int d = 0; d < 2; d++) begin
      if (rs) model_reset(d);
      else    model_step(d, r, h);
      push(d);
    end
    if (rs) begin
      #1;
      chk_zero("rst_held");
    end
  endtask

  // Reset pulse entirely between two edges; the following edge arbitrates from ptr=0.
  task automatic pulse_cyc(input logic [4:0] r, input logic h);
    @(negedge clk);
    req  = r;
    hold = h;
    rst  = 1'b1;
    #1;
    chk_zero("rst_pulse");
    #1;
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      model_reset(d);
      model_step(d, r, h);
      push(d);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        chk("free_grant", int'(g_free), int'(e.g));
        chk("free_id",    int'(id_free), int'(e.id));
        chk("free_valid", int'(v_free), int'(e.v));
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("hold_grant", int'(g_hold), int'(e.g));
        chk("hold_id",    int'(id_hold), int'(e.id));
        chk("hold_valid", int'(v_hold), int'(e.v));
      end
    end
  end

  initial begin
    logic [4:0] r;
    logic       h;
    for (int d = 0; d < 2; d++) model_reset(d);
    #1;
    chk_zero("rst_init");
    repeat (2) cyc(5'b11111, 1'b0, 1'b1);

    // full rotation 0,1,2,3,4,0,1
    repeat (7) cyc(5'b11111, 1'b0, 1'b0);

    // non-power-of-2 wrap: 3, then 4, then 0
    cyc(5'b01000, 1'b0, 1'b0);
    cyc(5'b10001, 1'b0, 1'b0);
    cyc(5'b10001, 1'b0, 1'b0);

    // lock on 1 in the hold build, alternation in the free build
    repeat (9) cyc(5'b00110, 1'b1, 1'b0);
    cyc(5'b00100, 1'b1, 1'b0);

    // idle after a grant of 2, then ptr 3 wraps to requester 0
    repeat (3) cyc(5'b00000, 1'b0, 1'b0);
    cyc(5'b00101, 1'b0, 1'b0);

    // lock on 3, then reset pulse mid-lock with release
    repeat (4) cyc(5'b01000, 1'b1, 1'b0);
    pulse_cyc(5'b11111, 1'b0);
    cyc(5'b11111, 1'b0, 1'b0);

    // hold_in with nothing granted has no effect
    cyc(5'b00000, 1'b1, 1'b0);
    cyc(5'b00000, 1'b1, 1'b0);
    cyc(5'b10000, 1'b1, 1'b0);

    r = 5'b10101;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) r = 5'($urandom);
      h = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 59) == 0) pulse_cyc(r, h);
      else                            cyc(r, h, 1'b0);
    end

    @(negedge clk);
    @(negedge clk);
    chk("queues_drained", q0.size() + q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
